// File: rtl/udp_rx.sv
// udp_rx -- GMII receive path that filters Ethernet/IPv4/UDP frames addressed
// to this board and delivers the UDP payload as big-endian 32-bit words.
//
// Ports
//   clk           GMII RX clock; everything is clocked on its rising edge
//   rst_n         synchronous active-low reset
//   gmii_rx_dv    receive data valid; bytes are only consumed while high
//   gmii_rxd      receive byte
//   rec_en        one-cycle strobe, rec_data holds a payload word
//   rec_data      payload word, first byte of the word in [31:24]
//   rec_pkt_done  one-cycle strobe, payload of the current packet complete
//   rec_byte_num  payload byte count, valid with rec_pkt_done
module udp_rx #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        rec_en,
  output logic [31:0] rec_data,
  output logic        rec_pkt_done,
  output logic [15:0] rec_byte_num
);

  typedef enum logic [6:0] {
    st_idle     = 7'b0000001,
    st_preamble = 7'b0000010,
    st_eth_head = 7'b0000100,
    st_ip_head  = 7'b0001000,
    st_udp_head = 7'b0010000,
    st_rx_data  = 7'b0100000,
    st_rx_end   = 7'b1000000
  } state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;        // byte index within the current header
  logic [3:0]  r_ihl;
  logic        r_mac_ok;     // destination MAC matched BOARD_MAC so far
  logic        r_bc_ok;      // destination MAC matched broadcast so far
  logic [7:0]  r_type_hi;
  logic [7:0]  r_len_hi;
  logic [15:0] r_payload;    // UDP length minus the 8-byte UDP header
  logic        r_len_short;  // UDP length below 8, frame is malformed
  logic [15:0] r_data_cnt;   // payload bytes already consumed
  logic [31:0] r_word;

  logic [7:0]  w_mac_byte;
  logic [7:0]  w_ip_byte;
  logic [5:0]  w_ip_last;
  logic [31:0] w_word_next;
  logic        w_last;

  // Expected MAC byte for header positions 0..5
  always_comb begin
    w_mac_byte = BOARD_MAC[7:0];
    case (r_cnt)
      6'd0:    w_mac_byte = BOARD_MAC[47:40];
      6'd1:    w_mac_byte = BOARD_MAC[39:32];
      6'd2:    w_mac_byte = BOARD_MAC[31:24];
      6'd3:    w_mac_byte = BOARD_MAC[23:16];
      6'd4:    w_mac_byte = BOARD_MAC[15:8];
      default: w_mac_byte = BOARD_MAC[7:0];
    endcase
  end

  // Destination IP occupies IP header bytes 16..19, so the low two index bits
  // select the byte directly.
  always_comb begin
    w_ip_byte = BOARD_IP[7:0];
    case (r_cnt[1:0])
      2'd0:    w_ip_byte = BOARD_IP[31:24];
      2'd1:    w_ip_byte = BOARD_IP[23:16];
      2'd2:    w_ip_byte = BOARD_IP[15:8];
      default: w_ip_byte = BOARD_IP[7:0];
    endcase
  end

  assign w_ip_last = {r_ihl, 2'b00} - 6'd1;
  assign w_last    = (r_data_cnt == (r_payload - 16'd1));

  // Insert the incoming byte into its big-endian lane; lane 0 starts a fresh
  // word so a trailing partial word comes out with zeroed low bytes.
  always_comb begin
    w_word_next = r_word;
    case (r_data_cnt[1:0])
      2'd0:    w_word_next = {gmii_rxd, 24'd0};
      2'd1:    w_word_next = {r_word[31:24], gmii_rxd, 16'd0};
      2'd2:    w_word_next = {r_word[31:16], gmii_rxd, 8'd0};
      default: w_word_next = {r_word[31:8], gmii_rxd};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= st_idle;
      r_cnt        <= 6'd0;
      r_ihl        <= 4'd0;
      r_mac_ok     <= 1'b0;
      r_bc_ok      <= 1'b0;
      r_type_hi    <= 8'd0;
      r_len_hi     <= 8'd0;
      r_payload    <= 16'd0;
      r_len_short  <= 1'b0;
      r_data_cnt   <= 16'd0;
      r_word       <= 32'd0;
      rec_en       <= 1'b0;
      rec_pkt_done <= 1'b0;
      rec_data     <= 32'd0;
      rec_byte_num <= 16'd0;
    end else begin
      rec_en       <= 1'b0;
      rec_pkt_done <= 1'b0;
      case (r_state)
        st_idle: begin
          if (gmii_rx_dv && gmii_rxd == 8'h55) begin
            r_state <= st_preamble;
            r_cnt   <= 6'd0;
          end
        end

        st_preamble: begin
          if (!gmii_rx_dv) begin
            r_state <= st_idle;
          end else if (gmii_rxd == 8'h55 && r_cnt < 6'd6) begin
            r_cnt <= r_cnt + 6'd1;
          end else if (gmii_rxd == 8'hd5 && r_cnt == 6'd6) begin
            r_state <= st_eth_head;
            r_cnt   <= 6'd0;
          end else begin
            r_state <= st_rx_end;
          end
        end

        st_eth_head: begin
          if (!gmii_rx_dv) begin
            r_state <= st_idle;
          end else begin
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt <= 6'd5) begin
              r_mac_ok <= ((r_cnt == 6'd0) | r_mac_ok) & (gmii_rxd == w_mac_byte);
              r_bc_ok  <= ((r_cnt == 6'd0) | r_bc_ok) & (gmii_rxd == 8'hff);
            end
            if (r_cnt == 6'd12)
              r_type_hi <= gmii_rxd;
            if (r_cnt == 6'd13) begin
              r_cnt <= 6'd0;
              if ((r_mac_ok || r_bc_ok) && r_type_hi == 8'h08 && gmii_rxd == 8'h00)
                r_state <= st_ip_head;
              else
                r_state <= st_rx_end;
            end
          end
        end

        st_ip_head: begin
          if (!gmii_rx_dv) begin
            r_state <= st_idle;
          end else if (r_cnt == 6'd0) begin
            if (gmii_rxd[7:4] != 4'd4 || gmii_rxd[3:0] < 4'd5) begin
              r_state <= st_rx_end;
            end else begin
              r_ihl <= gmii_rxd[3:0];
              r_cnt <= 6'd1;
            end
          end else if (r_cnt == 6'd9 && gmii_rxd != 8'd17) begin
            r_state <= st_rx_end;
          end else if (r_cnt >= 6'd16 && r_cnt <= 6'd19 && gmii_rxd != w_ip_byte) begin
            r_state <= st_rx_end;
          end else if (r_cnt == w_ip_last) begin
            r_state <= st_udp_head;
            r_cnt   <= 6'd0;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end

        st_udp_head: begin
          if (!gmii_rx_dv) begin
            r_state <= st_idle;
          end else begin
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'd4)
              r_len_hi <= gmii_rxd;
            if (r_cnt == 6'd5) begin
              r_payload   <= {r_len_hi, gmii_rxd} - 16'd8;
              r_len_short <= ({r_len_hi, gmii_rxd} < 16'd8);
            end
            if (r_cnt == 6'd7) begin
              r_cnt      <= 6'd0;
              r_data_cnt <= 16'd0;
              if (r_len_short) begin
                r_state <= st_rx_end;
              end else if (r_payload == 16'd0) begin
                // Empty datagram: report completion with nothing delivered
                rec_pkt_done <= 1'b1;
                rec_byte_num <= 16'd0;
                r_state      <= st_rx_end;
              end else begin
                r_state <= st_rx_data;
              end
            end
          end
        end

        st_rx_data: begin
          if (!gmii_rx_dv) begin
            r_state <= st_idle;
          end else begin
            r_word     <= w_word_next;
            r_data_cnt <= r_data_cnt + 16'd1;
            if (r_data_cnt[1:0] == 2'd3 || w_last) begin
              rec_en   <= 1'b1;
              rec_data <= w_word_next;
            end
            if (w_last) begin
              rec_pkt_done <= 1'b1;
              rec_byte_num <= r_payload;
              r_state      <= st_rx_end;
            end
          end
        end

        st_rx_end: begin
          // Swallow padding/FCS until the frame ends
          if (!gmii_rx_dv)
            r_state <= st_idle;
        end

        default: r_state <= st_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_rx.sv
// tb_udp_rx -- directed frames for udp_rx with hand-computed expected words.
module tb_udp_rx;

  localparam logic [47:0] MAC = 48'h00_11_22_33_44_55;
  localparam logic [31:0] IP  = {8'd192, 8'd168, 8'd1, 8'd10};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gmii_rx_dv;
  logic [7:0]  gmii_rxd;
  logic        rec_en;
  logic [31:0] rec_data;
  logic        rec_pkt_done;
  logic [15:0] rec_byte_num;

  udp_rx #(.BOARD_MAC(MAC), .BOARD_IP(IP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gmii_rx_dv   (gmii_rx_dv),
    .gmii_rxd     (gmii_rxd),
    .rec_en       (rec_en),
    .rec_data     (rec_data),
    .rec_pkt_done (rec_pkt_done),
    .rec_byte_num (rec_byte_num)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  frm[$];
  logic [7:0]  pl[$];
  int          frm_last_pl;
  int          last_samp_cyc;

  logic [31:0] en_q[$];
  logic [15:0] done_q[$];
  int          done_cyc;
  logic        done_en;

  // Strobe monitor
  always @(negedge clk) begin
    if (rec_en) en_q.push_back(rec_data);
    if (rec_pkt_done) begin
      done_q.push_back(rec_byte_num);
      done_cyc = cyc;
      done_en  = rec_en;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    en_q.delete();
    done_q.delete();
    done_cyc      = -1;
    done_en       = 1'b0;
    last_samp_cyc = -2;
  endtask

  task automatic build(input logic [47:0] dmac, input logic [31:0] dip,
                       input logic [7:0] proto, input logic [3:0] ihl);
    logic [47:0] smac;
    logic [31:0] sip;
    logic [15:0] ulen;
    logic [15:0] tot;
    smac = 48'h02_aa_bb_cc_dd_ee;
    sip  = {8'd192, 8'd168, 8'd1, 8'd2};
    ulen = 16'(8 + pl.size());
    tot  = 16'(int'(ihl) * 4) + ulen;
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hd5);
    for (int i = 0; i < 6; i++) frm.push_back(dmac[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(smac[47-8*i -: 8]);
    frm.push_back(8'h08); frm.push_back(8'h00);
    frm.push_back({4'h4, ihl}); frm.push_back(8'h00);
    frm.push_back(tot[15:8]); frm.push_back(tot[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h01);
    frm.push_back(8'h40); frm.push_back(8'h00);
    frm.push_back(8'h40); frm.push_back(proto);
    frm.push_back(8'h00); frm.push_back(8'h00);
    for (int i = 0; i < 4; i++) frm.push_back(sip[31-8*i -: 8]);
    for (int i = 0; i < 4; i++) frm.push_back(dip[31-8*i -: 8]);
    for (int i = 0; i < (int'(ihl) - 5) * 4; i++) frm.push_back(8'h00);
    frm.push_back(8'h04); frm.push_back(8'hd2);
    frm.push_back(8'h16); frm.push_back(8'h2e);
    frm.push_back(ulen[15:8]); frm.push_back(ulen[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h00);
    frm_last_pl = -1;
    foreach (pl[i]) begin
      frm.push_back(pl[i]);
      frm_last_pl = frm.size() - 1;
    end
    while (frm.size() - 8 < 60) frm.push_back(8'h00);
    frm.push_back(8'hde); frm.push_back(8'had);
    frm.push_back(8'hbe); frm.push_back(8'hef);
  endtask

  // Drive the built frame; abort_at drops dv at that byte index, rst_at
  // holds reset low for two bytes starting at that index.
  task automatic send(input int abort_at, input int rst_at, input int gap);
    clear_mon();
    for (int i = 0; i <= frm.size(); i++) begin
      @(posedge clk); #1;
      if (i == rst_at) rst_n = 1'b0;
      if (i == rst_at + 2) rst_n = 1'b1;
      if (i == frm.size() || i == abort_at) begin
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        break;
      end
      gmii_rx_dv = 1'b1;
      gmii_rxd   = frm[i];
      if (i == frm_last_pl) last_samp_cyc = cyc + 1;
      if (i == rst_at + 1) begin
        @(negedge clk);
        chk("rst_mid_en",    32'(rec_en),       32'd0);
        chk("rst_mid_done",  32'(rec_pkt_done), 32'd0);
        chk("rst_mid_data",  rec_data,          32'd0);
        chk("rst_mid_bytes", 32'(rec_byte_num), 32'd0);
      end
    end
    repeat (gap) @(posedge clk);
    #2;
  endtask

  task automatic expect_rx(input string tag, input int nw, input logic [31:0] w0,
                           input logic [31:0] w1, input logic [15:0] nb);
    chk({tag, "_en_cnt"},   32'(en_q.size()),   32'(nw));
    if (nw > 0) chk({tag, "_w0"}, (en_q.size() > 0) ? en_q[0] : 32'hxxxxxxxx, w0);
    if (nw > 1) chk({tag, "_w1"}, (en_q.size() > 1) ? en_q[1] : 32'hxxxxxxxx, w1);
    chk({tag, "_done_cnt"}, 32'(done_q.size()), 32'd1);
    chk({tag, "_bytes"},    (done_q.size() > 0) ? 32'(done_q[0]) : 32'hxxxxxxxx, 32'(nb));
    if (nw > 0) begin
      chk({tag, "_latency"},  32'(done_cyc), 32'(last_samp_cyc));
      chk({tag, "_done_w_en"}, 32'(done_en), 32'd1);
    end
  endtask

  task automatic expect_none(input string tag);
    chk({tag, "_en_cnt"},   32'(en_q.size()),   32'd0);
    chk({tag, "_done_cnt"}, 32'(done_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_en",    32'(rec_en),       32'd0);
    chk("reset_done",  32'(rec_pkt_done), 32'd0);
    chk("reset_data",  rec_data,          32'd0);
    chk("reset_bytes", 32'(rec_byte_num), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Unicast, payload 01..08
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    build(MAC, IP, 8'd17, 4'd5);
    send(-1, -10, 12);
    expect_rx("unicast8", 2, 32'h01020304, 32'h05060708, 16'd8);

    // Broadcast, 5-byte payload padded to minimum frame
    pl = '{8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee};
    build(48'hff_ff_ff_ff_ff_ff, IP, 8'd17, 4'd5);
    send(-1, -10, 12);
    expect_rx("bcast5", 2, 32'haabbccdd, 32'hee000000, 16'd5);

    // Wrong destination IP: dropped, outputs hold last values
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    build(MAC, {8'd192, 8'd168, 8'd1, 8'd11}, 8'd17, 4'd5);
    send(-1, -10, 12);
    expect_none("wrong_ip");
    chk("hold_data",  rec_data,          32'hee000000);
    chk("hold_bytes", 32'(rec_byte_num), 32'd5);

    // Protocol 6 (TCP): dropped
    build(MAC, IP, 8'd6, 4'd5);
    send(-1, -10, 12);
    expect_none("proto_tcp");

    // Wrong destination MAC: dropped
    build(48'h00_11_22_33_44_56, IP, 8'd17, 4'd5);
    send(-1, -10, 12);
    expect_none("wrong_mac");

    // Valid 3-byte frame after the drops
    pl = '{8'h10, 8'h20, 8'h30};
    build(MAC, IP, 8'd17, 4'd5);
    send(-1, -10, 12);
    expect_rx("after_drop3", 1, 32'h10203000, 32'h0, 16'd3);

    // IHL=6 with one option word
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    build(MAC, IP, 8'd17, 4'd6);
    send(-1, -10, 12);
    expect_rx("ihl6", 1, 32'h11223344, 32'h0, 16'd4);

    // dv dropped during payload byte 3 of 8, then back-to-back valid frame
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    build(MAC, IP, 8'd17, 4'd5);
    send(8 + 14 + 20 + 8 + 2, -10, 1);
    expect_none("abort_pl3");
    pl = '{8'hc1, 8'hc2, 8'hc3, 8'hc4, 8'hc5, 8'hc6};
    build(MAC, IP, 8'd17, 4'd5);
    send(-1, -10, 12);
    expect_rx("b2b6", 2, 32'hc1c2c3c4, 32'hc5c60000, 16'd6);

    // Reset for two cycles in the middle of the IP header
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    build(MAC, IP, 8'd17, 4'd5);
    send(-1, 8 + 14 + 10, 12);
    expect_none("rst_frame");
    pl = '{8'h9a, 8'h8b, 8'h7c, 8'h6d, 8'h5e, 8'h4f, 8'h30};
    build(MAC, IP, 8'd17, 4'd5);
    send(-1, -10, 12);
    expect_rx("post_rst7", 2, 32'h9a8b7c6d, 32'h5e4f3000, 16'd7);

    // Empty UDP datagram (length 8)
    pl.delete();
    build(MAC, IP, 8'd17, 4'd5);
    send(-1, -10, 12);
    expect_rx("empty", 0, 32'h0, 32'h0, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
